// File: rtl/kamus_csr_counters_if.sv
// CSR request/response bus between the EX stage and the counter/timer block.
// The EX stage drives the request; the counter block returns a registered response.
interface kamus_csr_counters_if;
  logic [11:0] csr_addr_i;
  logic        csr_rd_en_i;
  logic        csr_wr_en_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_valid_o;
  logic        csr_illegal_o;

  modport master (
    output csr_addr_i, csr_rd_en_i, csr_wr_en_i, csr_op_i, csr_wdata_i,
    input  csr_rdata_o, csr_valid_o, csr_illegal_o
  );

  modport slave (
    input  csr_addr_i, csr_rd_en_i, csr_wr_en_i, csr_op_i, csr_wdata_i,
    output csr_rdata_o, csr_valid_o, csr_illegal_o
  );
endinterface

// File: rtl/kamus_csr_counters.sv
// Machine counter/timer CSRs for kamus: mcycle, mtime, minstret, hpm counters,
// mtimecmp and mcountinhibit, with a registered CSR response and the timer interrupt.
module kamus_csr_counters #(
  parameter int NUM_HPM       = 2,
  parameter int CNT_WIDTH     = 64,
  parameter int TIME_PRESCALE = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  kamus_csr_counters_if.slave csr,
  input  logic                instr_retired_i,
  input  logic [NUM_HPM-1:0]  hpm_event_i,
  output logic                timer_irq_o
);
  // Counter slots share the CSR index: 0 mcycle, 1 mtime, 2 minstret, 3+i hpm(i).
  localparam int NUM_CNT = 3 + NUM_HPM;
  localparam int PS_W    = (TIME_PRESCALE > 1) ? $clog2(TIME_PRESCALE) : 1;
  localparam logic [31:0] INH_MASK = 32'((64'd1 << NUM_CNT) - 64'd1) & ~32'd2;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
  logic [CNT_WIDTH-1:0] mtimecmp;
  logic [31:0]          inhibit;
  logic [PS_W-1:0]      prescale;

  logic                 req, hit_cnt, hit_cmp, hit_inh, read_only, hi_half;
  logic                 eff_wr, illegal, do_wr, tick;
  logic [63:0]          old64, wr64;
  logic [31:0]          old32, new32;
  logic [CNT_WIDTH-1:0] wr_val;
  logic [NUM_CNT-1:0]   inc;
  op_e                  op;

  assign op   = op_e'(csr.csr_op_i);
  assign req  = csr.csr_rd_en_i | csr.csr_wr_en_i;
  assign tick = (prescale == PS_W'(TIME_PRESCALE - 1));

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; a missing default infers a latch.
  always_comb begin
    hit_cnt   = 1'b0;
    hit_cmp   = 1'b0;
    hit_inh   = 1'b0;
    read_only = 1'b0;
    hi_half   = 1'b0;
    old64     = '0;
    if ((csr.csr_addr_i[11:8] == 4'hF || csr.csr_addr_i[11:8] == 4'hC) &&
        csr.csr_addr_i[6:5] == 2'b00) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (csr.csr_addr_i[4:0] == 5'(k)) begin
          hit_cnt = 1'b1;
          old64   = 64'(cnt[k]);
        end
      end
      read_only = (csr.csr_addr_i[11:8] == 4'hC);
      hi_half   = csr.csr_addr_i[7];
    end else if (csr.csr_addr_i == 12'h7C1 || csr.csr_addr_i == 12'h7C2) begin
      hit_cmp = 1'b1;
      hi_half = (csr.csr_addr_i == 12'h7C2);
      old64   = 64'(mtimecmp);
    end else if (csr.csr_addr_i == 12'h320) begin
      hit_inh = 1'b1;
      old64   = 64'(inhibit);
    end
  end

  always_comb begin
    old32 = hi_half ? old64[63:32] : old64[31:0];
    unique case (op)
      OP_SET:   new32 = old32 | csr.csr_wdata_i;
      OP_CLEAR: new32 = old32 & ~csr.csr_wdata_i;
      default:  new32 = csr.csr_wdata_i;
    endcase
    // Set/clear with a zero operand is a pure read, so it stays legal on mirrors.
    eff_wr  = csr.csr_wr_en_i && (op == OP_WRITE ||
              ((op == OP_SET || op == OP_CLEAR) && csr.csr_wdata_i != 32'd0));
    illegal = req && (!(hit_cnt || hit_cmp || hit_inh) ||
                      (csr.csr_wr_en_i && op == OP_NONE) ||
                      (read_only && eff_wr));
    do_wr   = eff_wr && !illegal;
    wr64    = hi_half ? {new32, old64[31:0]} : {old64[63:32], new32};
    wr_val  = CNT_WIDTH'(wr64);
  end

  always_comb begin
    inc    = '0;
    inc[0] = ~inhibit[0];
    inc[1] = tick;
    inc[2] = instr_retired_i & ~inhibit[2];
    for (int i = 0; i < NUM_HPM; i++) inc[3+i] = hpm_event_i[i] & ~inhibit[3+i];
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; the counter array is architectural state and is fully reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CNT; k++) cnt[k] <= '0;
      mtimecmp          <= '1;
      inhibit           <= '0;
      prescale          <= '0;
      timer_irq_o       <= 1'b0;
      csr.csr_rdata_o   <= '0;
      csr.csr_valid_o   <= 1'b0;
      csr.csr_illegal_o <= 1'b0;
    end else begin
      prescale <= tick ? '0 : prescale + PS_W'(1);
      // A write to either half replaces that cycle's increment.
      for (int k = 0; k < NUM_CNT; k++) begin
        if (do_wr && hit_cnt && csr.csr_addr_i[4:0] == 5'(k)) cnt[k] <= wr_val;
        else if (inc[k])                                     cnt[k] <= cnt[k] + CNT_WIDTH'(1);
      end
      if (do_wr && hit_cmp) mtimecmp <= wr_val;
      if (do_wr && hit_inh) inhibit  <= new32 & INH_MASK;
      timer_irq_o       <= (cnt[1] >= mtimecmp);
      csr.csr_valid_o   <= req;
      csr.csr_illegal_o <= illegal;
      csr.csr_rdata_o   <= (req && !illegal) ? old32 : 32'd0;
    end
  end
endmodule

// File: tb/tb_kamus_csr_counters.sv
// Directed bench for kamus_csr_counters (NUM_HPM=2, CNT_WIDTH=64, TIME_PRESCALE=4).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_kamus_csr_counters;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       instr_retired_i = 1'b0;
  logic [1:0] hpm_event_i = 2'b00;
  logic       timer_irq_o;

  kamus_csr_counters_if csr ();

  kamus_csr_counters #(.NUM_HPM(2), .CNT_WIDTH(64), .TIME_PRESCALE(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .csr             (csr),
    .instr_retired_i (instr_retired_i),
    .hpm_event_i     (hpm_event_i),
    .timer_irq_o     (timer_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] r_data;
  logic        r_valid, r_ill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    csr.csr_addr_i  = 12'h000;
    csr.csr_rd_en_i = 1'b0;
    csr.csr_wr_en_i = 1'b0;
    csr.csr_op_i    = 2'b00;
    csr.csr_wdata_i = 32'd0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // One request cycle; the response is captured just after the closing edge.
  task automatic req(input logic [11:0] a, input logic rd, input logic wr,
                     input logic [1:0] op, input logic [31:0] wd);
    csr.csr_addr_i  = a;
    csr.csr_rd_en_i = rd;
    csr.csr_wr_en_i = wr;
    csr.csr_op_i    = op;
    csr.csr_wdata_i = wd;
    cycles(1);
    idle_bus();
    r_data  = csr.csr_rdata_o;
    r_valid = csr.csr_valid_o;
    r_ill   = csr.csr_illegal_o;
  endtask

  task automatic rd(input logic [11:0] a);                       req(a, 1'b1, 1'b0, 2'b10, 32'd0); endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d); req(a, 1'b0, 1'b1, 2'b01, d);     endtask
  task automatic setb(input logic [11:0] a, input logic [31:0] d); req(a, 1'b1, 1'b1, 2'b10, d);   endtask
  task automatic clrb(input logic [11:0] a, input logic [31:0] d); req(a, 1'b1, 1'b1, 2'b11, d);   endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    #12;
    cycles(1);
    rst_ni = 1'b1;
    check("rst_valid", 32'(csr.csr_valid_o), 32'd0);
    check("rst_rdata", csr.csr_rdata_o, 32'd0);
    check("rst_illegal", 32'(csr.csr_illegal_o), 32'd0);
    check("rst_irq", 32'(timer_irq_o), 32'd0);

    // 10 edges after release -> mcycle = 10 at the request edge.
    cycles(10);
    rd(12'hC00);
    check("c00_valid", 32'(r_valid), 32'd1);
    check("c00_data", r_data, 32'd10);
    check("c00_illegal", 32'(r_ill), 32'd0);
    check("c00_irq", 32'(timer_irq_o), 32'd0);
    cycles(1);
    check("valid_one_shot", 32'(csr.csr_valid_o), 32'd0);

    // Carry from the low half into the high half.
    wr(12'hF00, 32'hFFFF_FFFF);
    wr(12'hF80, 32'h0000_0000);
    cycles(1);
    rd(12'hF80);
    check("carry_hi", r_data, 32'h0000_0001);
    rd(12'hF00);
    check("carry_lo", r_data, 32'h0000_0001);

    // mtime steps exactly once in any 4 consecutive edges; the write edge's tick is lost.
    wr(12'hF01, 32'h10);
    cycles(4);
    rd(12'hF01);
    check("mtime_step1", r_data, 32'h11);
    cycles(3);
    rd(12'hF01);
    check("mtime_step2", r_data, 32'h12);
    rd(12'hF81);
    check("mtime_hi", r_data, 32'h0);

    // Timer interrupt.
    wr(12'hF01, 32'd0);
    wr(12'h7C1, 32'd3);
    wr(12'h7C2, 32'd0);
    check("irq_low_before", 32'(timer_irq_o), 32'd0);
    for (int i = 0; i < 13 && !timer_irq_o; i++) cycles(1);
    check("irq_rise", 32'(timer_irq_o), 32'd1);
    wr(12'h7C1, 32'd100);
    check("irq_hold_on_write_edge", 32'(timer_irq_o), 32'd1);
    cycles(1);
    check("irq_drop", 32'(timer_irq_o), 32'd0);
    rd(12'h7C1);
    check("mtimecmp_lo", r_data, 32'd100);

    // mcountinhibit gating of minstret.
    setb(12'h320, 32'd4);
    check("inh_set_old", r_data, 32'd0);
    instr_retired_i = 1'b1;
    cycles(5);
    instr_retired_i = 1'b0;
    rd(12'hF02);
    check("minstret_inhibited", r_data, 32'd0);
    rd(12'h320);
    check("inh_readback", r_data, 32'd4);
    clrb(12'h320, 32'd4);
    instr_retired_i = 1'b1;
    cycles(5);
    instr_retired_i = 1'b0;
    rd(12'hF02);
    check("minstret_counted", r_data, 32'd5);

    // Same-cycle inhibit write: the old inhibit value gates the retire.
    instr_retired_i = 1'b1;
    setb(12'h320, 32'd4);
    instr_retired_i = 1'b0;
    rd(12'hF02);
    check("inh_write_race", r_data, 32'd6);
    clrb(12'h320, 32'd4);
    instr_retired_i = 1'b1;
    wr(12'hF02, 32'd50);
    instr_retired_i = 1'b0;
    rd(12'hF02);
    check("write_beats_retire", r_data, 32'd50);

    // Hardwired inhibit bits and a frozen mcycle.
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320);
    check("inh_mask", r_data, 32'h0000_001D);
    wr(12'hF00, 32'h100);
    cycles(3);
    rd(12'hF00);
    check("mcycle_frozen", r_data, 32'h100);
    wr(12'h320, 32'd0);

    // HPM counters.
    hpm_event_i = 2'b10;
    cycles(3);
    hpm_event_i = 2'b00;
    rd(12'hF04);
    check("hpm1", r_data, 32'd3);
    rd(12'hF03);
    check("hpm0", r_data, 32'd0);
    rd(12'hC84);
    check("hpm1_hi_mirror", r_data, 32'd0);
    check("hpm1_hi_legal", 32'(r_ill), 32'd0);

    // Illegal accesses.
    rd(12'hF05);
    check("f05_illegal", 32'(r_ill), 32'd1);
    check("f05_data", r_data, 32'd0);
    check("f05_valid", 32'(r_valid), 32'd1);
    wr(12'hF00, 32'd0);
    wr(12'hC00, 32'd5);
    check("c00_write_illegal", 32'(r_ill), 32'd1);
    rd(12'hC00);
    check("mcycle_after_ro_write", r_data, 32'd1);
    setb(12'hC00, 32'd0);
    check("c00_set0_legal", 32'(r_ill), 32'd0);
    check("c00_set0_data", r_data, 32'd2);
    req(12'hF00, 1'b0, 1'b1, 2'b00, 32'd7);
    check("op00_illegal", 32'(r_ill), 32'd1);
    rd(12'h123);
    check("unmapped_illegal", 32'(r_ill), 32'd1);

    // Reset in the middle of a request.
    csr.csr_addr_i  = 12'h7C1;
    csr.csr_rd_en_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    idle_bus();
    cycles(1);
    check("mid_rst_valid", 32'(csr.csr_valid_o), 32'd0);
    check("mid_rst_rdata", csr.csr_rdata_o, 32'd0);
    check("mid_rst_illegal", 32'(csr.csr_illegal_o), 32'd0);
    check("mid_rst_irq", 32'(timer_irq_o), 32'd0);
    rst_ni = 1'b1;
    cycles(1);
    check("post_rst_valid", 32'(csr.csr_valid_o), 32'd0);
    rd(12'h7C1);
    check("post_rst_cmp_lo", r_data, 32'hFFFF_FFFF);
    rd(12'h7C2);
    check("post_rst_cmp_hi", r_data, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
